// File: rtl/dac_sample_arbiter.sv
// Shares one 8-bit DAC between N_SRC sample sources. Divides clk down to the DAC
// sample clock and grants one slot per sample period, round-robin.
module dac_sample_arbiter #(
  parameter int         N_SRC     = 4,
  parameter int         DIV       = 10,
  parameter logic [7:0] IDLE_CODE = 8'h80
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [8*N_SRC-1:0]       src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic                     dac_clk,
  output logic [7:0]               dout,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     underrun
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ARB  = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_RISE = CW'(DIV / 2 - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_dac_clk;
  logic [7:0]       r_dout;
  logic [N_SRC-1:0] r_src_ready;
  logic [IW-1:0]    r_gnt_idx;
  logic             r_underrun;
  logic             r_gnt_vld;
  logic [IW-1:0]    r_gnt;
  logic [IW-1:0]    r_last_gnt;

  logic [IW-1:0]    w_win;
  logic             w_any;
  logic             w_gnt_valid;
  logic [7:0]       w_gnt_data;

  // Round-robin search: the source after the last one served has top priority.
  always_comb begin
    int            w_idx;
    logic [IW-1:0] w_sel;
    w_idx = 0;
    w_sel = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      w_idx = (int'(r_last_gnt) + i) % N_SRC;
      w_sel = w_idx[IW-1:0];
      if (!w_any && src_valid[w_sel]) begin
        w_any = 1'b1;
        w_win = w_sel;
      end
    end
  end

  assign w_gnt_valid = src_valid[r_gnt];
  assign w_gnt_data  = src_data[{r_gnt, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_dac_clk   <= 1'b0;
      r_dout      <= IDLE_CODE;
      r_src_ready <= '0;
      r_gnt_idx   <= '0;
      r_underrun  <= 1'b0;
      r_gnt_vld   <= 1'b0;
      r_gnt       <= '0;
      r_last_gnt  <= IW'(N_SRC - 1);
    end else if (!en) begin
      // Pending grant is dropped; dout and the round-robin pointer are kept.
      r_cnt       <= '0;
      r_dac_clk   <= 1'b0;
      r_src_ready <= '0;
      r_underrun  <= 1'b0;
      r_gnt_vld   <= 1'b0;
    end else begin
      r_cnt       <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      r_src_ready <= '0;
      r_underrun  <= 1'b0;

      if (r_cnt == CNT_RISE) begin
        r_dac_clk <= 1'b1;
      end

      if (r_cnt == CNT_ARB) begin
        r_gnt       <= w_win;
        r_gnt_vld   <= w_any;
        r_underrun  <= !w_any;
        r_src_ready <= w_any ? (N_SRC'(1) << w_win) : '0;
      end

      // Launch coincides with the falling dac_clk edge, centring dout on the rise.
      if (r_cnt == CNT_LAST) begin
        r_dac_clk <= 1'b0;
        r_gnt_vld <= 1'b0;
        if (r_gnt_vld && w_gnt_valid) begin
          r_dout     <= w_gnt_data;
          r_gnt_idx  <= r_gnt;
          r_last_gnt <= r_gnt;
        end else begin
          r_dout <= IDLE_CODE;
        end
      end
    end
  end

  assign src_ready = r_src_ready;
  assign dac_clk   = r_dac_clk;
  assign dout      = r_dout;
  assign gnt_idx   = r_gnt_idx;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Bench for dac_sample_arbiter: slot-level reference model of the arbiter plus
// behavioural sources that hold valid/data until they see src_ready.
module tb_dac_sample_arbiter;

  localparam int N   = 4;
  localparam int DIV = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   src_valid = '0;
  logic [8*N-1:0] src_data = '0;
  logic [N-1:0]   src_ready;
  logic           dac_clk;
  logic [7:0]     dout;
  logic [1:0]     gnt_idx;
  logic           underrun;

  dac_sample_arbiter #(.N_SRC(N), .DIV(DIV), .IDLE_CODE(8'h80)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .dac_clk(dac_clk), .dout(dout), .gnt_idx(gnt_idx),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Source behaviour
  logic [N-1:0] want = '0;
  logic [7:0]   sdata [N];
  logic [N-1:0] ramp = '0;
  logic [N-1:0] seen_rdy = '0;
  logic [N-1:0] consumed = '0;

  // Reference model state: t is clocks since the current sample period began
  int         t = 0;
  logic [7:0] e_dout = 8'h80;
  logic [1:0] e_gnt = '0;
  logic [N-1:0] e_ready = '0;
  logic       e_under = 1'b0;
  logic       e_dac = 1'b0;
  logic [1:0] m_last = 2'(N - 1);
  logic       m_pend = 1'b0;
  logic [1:0] m_win = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] act_vec;
  assign act_vec = {dout, gnt_idx, src_ready, underrun, dac_clk};

  function automatic logic [15:0] exp_vec();
    return {e_dout, e_gnt, e_ready, e_under, e_dac};
  endfunction

  // Drive inputs, predict the effect of the coming edge, then step past it.
  task automatic tick();
    logic [1:0] ix;
    for (int i = 0; i < N; i++) src_data[8*i +: 8] = sdata[i];
    src_valid = want;
    if (!rst_n) begin
      t = 0; e_dout = 8'h80; e_gnt = '0; e_ready = '0; e_under = 1'b0;
      e_dac = 1'b0; m_last = 2'(N - 1); m_pend = 1'b0;
    end else if (!en) begin
      t = 0; e_dac = 1'b0; e_ready = '0; e_under = 1'b0; m_pend = 1'b0;
    end else begin
      e_ready = '0;
      e_under = 1'b0;
      if (t == DIV - 2) begin
        m_pend = 1'b0;
        for (int k = 1; k <= N; k++) begin
          ix = 2'((int'(m_last) + k) % N);
          if (!m_pend && want[ix]) begin
            m_pend = 1'b1;
            m_win = ix;
          end
        end
        e_under = !m_pend;
        if (m_pend) e_ready[m_win] = 1'b1;
      end else if (t == DIV - 1) begin
        if (m_pend && want[m_win]) begin
          e_dout = sdata[m_win];
          e_gnt = m_win;
          m_last = m_win;
        end else begin
          e_dout = 8'h80;
        end
        m_pend = 1'b0;
      end
      t = (t + 1) % DIV;
      e_dac = (t >= DIV / 2);
    end
    @(posedge clk);
    #1;
    consumed = seen_rdy;
    seen_rdy = src_ready;
    for (int i = 0; i < N; i++) if (consumed[i] && ramp[i]) sdata[i] = sdata[i] + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    want = '0;
    ramp = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    want = '1;
    ramp = '0;
    for (int i = 0; i < N; i++) sdata[i] = 8'(8'h10 * (i + 1));
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({dout, dac_clk, src_ready, underrun} !== {8'h80, 1'b0, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got dout=%h dac=%b rdy=%b und=%b want 80/0/0000/0",
                 c, dout, dac_clk, src_ready, underrun);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < DIV; c++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release t=%0d got %h want %h", t, act_vec, exp_vec());
      end
      if (c == DIV - 2) begin
        n_checks++;
        if (src_ready !== 4'b0001) begin
          n_fail++;
          $display("FAIL first_grant got rdy=%b want 0001", src_ready);
        end
      end
    end
    n_checks++;
    if (gnt_idx !== 2'd0 || dout !== 8'h10) begin
      n_fail++;
      $display("FAIL first_launch got idx=%0d dout=%h want 0/10", gnt_idx, dout);
    end
  endtask

  task automatic test_single_ramp();
    logic [7:0] prev_dout;
    logic       prev_dac;
    logic [7:0] ramp_exp;
    do_reset();
    en = 1'b1;
    want = 4'b0001;
    ramp = 4'b0001;
    sdata[0] = 8'h00;
    prev_dout = dout;
    prev_dac = dac_clk;
    ramp_exp = 8'h00;
    for (int c = 0; c < 7 * DIV; c++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL ramp_cycle t=%0d got %h want %h", t, act_vec, exp_vec());
      end
      n_checks++;
      if (dout !== prev_dout && !(prev_dac && !dac_clk)) begin
        n_fail++;
        $display("FAIL dout_timing t=%0d dout %h->%h without dac_clk fall", t, prev_dout, dout);
      end
      if (prev_dac && !dac_clk) begin
        n_checks++;
        if (dout !== ramp_exp) begin
          n_fail++;
          $display("FAIL ramp_step got %h want %h", dout, ramp_exp);
        end
        ramp_exp = ramp_exp + 8'd1;
      end
      prev_dout = dout;
      prev_dac = dac_clk;
    end
    $display("single ramp: last dout=%h", dout);
  endtask

  task automatic test_all_sources();
    logic prev_dac;
    int   exp_seq;
    int   pulses;
    do_reset();
    en = 1'b1;
    want = 4'b1111;
    for (int i = 0; i < N; i++) sdata[i] = 8'(8'h10 * (i + 1));
    prev_dac = dac_clk;
    exp_seq = 0;
    pulses = 0;
    for (int c = 0; c < 8 * DIV; c++) begin
      tick();
      pulses += $countones(src_ready);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL all_cycle t=%0d got %h want %h", t, act_vec, exp_vec());
      end
      if (prev_dac && !dac_clk) begin
        n_checks++;
        if (gnt_idx !== 2'(exp_seq) || dout !== 8'(8'h10 * (exp_seq + 1)) || pulses != 1) begin
          n_fail++;
          $display("FAIL all_rr got idx=%0d dout=%h pulses=%0d want %0d/%h/1",
                   gnt_idx, dout, pulses, exp_seq, 8'(8'h10 * (exp_seq + 1)));
        end
        exp_seq = (exp_seq + 1) % N;
        pulses = 0;
      end
      prev_dac = dac_clk;
    end
    $display("all sources: 8 slots round-robin, last idx=%0d", gnt_idx);
  endtask

  task automatic test_pair_then_idle();
    logic prev_dac;
    int   exp_src;
    int   unders;
    do_reset();
    en = 1'b1;
    want = 4'b1010;
    sdata[1] = 8'hA1;
    sdata[3] = 8'hA3;
    prev_dac = dac_clk;
    exp_src = 1;
    for (int c = 0; c < 4 * DIV; c++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL pair_cycle t=%0d got %h want %h", t, act_vec, exp_vec());
      end
      if (prev_dac && !dac_clk) begin
        n_checks++;
        if (gnt_idx !== 2'(exp_src) || dout !== ((exp_src == 1) ? 8'hA1 : 8'hA3)) begin
          n_fail++;
          $display("FAIL pair_alt got idx=%0d dout=%h want src %0d", gnt_idx, dout, exp_src);
        end
        exp_src = (exp_src == 1) ? 3 : 1;
      end
      prev_dac = dac_clk;
    end
    want = '0;
    unders = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      tick();
      unders += int'(underrun);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_cycle t=%0d got %h want %h", t, act_vec, exp_vec());
      end
      if (prev_dac && !dac_clk) begin
        n_checks++;
        if (dout !== 8'h80 || gnt_idx !== 2'd3 || unders != 1) begin
          n_fail++;
          $display("FAIL idle_slot got dout=%h idx=%0d unders=%0d want 80/3/1", dout, gnt_idx, unders);
        end
        unders = 0;
      end
      prev_dac = dac_clk;
    end
    $display("pair then idle: dout=%h idx=%0d", dout, gnt_idx);
  endtask

  task automatic test_late_request();
    for (int c = 0; c < 2 * DIV && t != DIV - 1; c++) tick();
    want[2] = 1'b1;
    sdata[2] = 8'h5A;
    n_checks++;
    if (src_ready !== 4'b0000 || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL late_slot got rdy=%b und=%b want 0000/1", src_ready, underrun);
    end
    tick();
    n_checks++;
    if (dout !== 8'h80 || act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL late_not_granted got %h want %h", act_vec, exp_vec());
    end
    for (int c = 0; c < DIV - 1; c++) tick();
    n_checks++;
    if (src_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL late_grant got rdy=%b want 0100", src_ready);
    end
    tick();
    want[2] = 1'b0;
    n_checks++;
    if (dout !== 8'h5A || gnt_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL late_launch got dout=%h idx=%0d want 5A/2", dout, gnt_idx);
    end
    $display("late request: src 2 served one period later");
  endtask

  task automatic test_en_drop();
    logic [7:0] saved;
    int         k;
    want = 4'b1111;
    for (int i = 0; i < N; i++) sdata[i] = 8'(8'h10 * (i + 1));
    for (int c = 0; c < 2 * DIV && t != DIV - 1; c++) tick();
    n_checks++;
    if (act_vec !== exp_vec() || src_ready === 4'b0000) begin
      n_fail++;
      $display("FAIL endrop_grant got %h want %h", act_vec, exp_vec());
    end
    saved = dout;
    en = 1'b0;
    tick();
    n_checks++;
    if (dout !== saved || dac_clk !== 1'b0 || src_ready !== 4'b0000 || act_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL endrop_hold got dout=%h dac=%b rdy=%b want dout=%h dac=0 rdy=0000",
               dout, dac_clk, src_ready, saved);
    end
    tick();
    en = 1'b1;
    k = 0;
    while (dac_clk !== 1'b1 && k < 3 * DIV) begin
      tick();
      k++;
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL enre_cycle t=%0d got %h want %h", t, act_vec, exp_vec());
      end
    end
    n_checks++;
    if (k != DIV / 2) begin
      n_fail++;
      $display("FAIL enre_rise got %0d clks want %0d", k, DIV / 2);
    end
    $display("en drop: dout held at %h, dac_clk rose after %0d clks", dout, k);
  endtask

  task automatic test_random();
    for (int c = 0; c < 40 * DIV; c++) begin
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle c=%0d t=%0d got %h want %h", c, t, act_vec, exp_vec());
      end
      for (int i = 0; i < N; i++) begin
        if (consumed[i]) begin
          want[i] = 1'($urandom_range(0, 1));
          sdata[i] = 8'($urandom);
        end else if (!want[i] && $urandom_range(0, 2) == 0) begin
          want[i] = 1'b1;
          sdata[i] = 8'($urandom);
        end
      end
      en = ($urandom_range(0, 39) != 0);
    end
    en = 1'b1;
    $display("random: 400 cycles done");
  endtask

  initial begin
    for (int i = 0; i < N; i++) sdata[i] = 8'h00;
    test_reset();
    test_single_ramp();
    test_all_sources();
    test_pair_then_idle();
    test_late_request();
    test_en_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
